data_narrow_unit: RTL and testbench

- Narrows 32-bit datapath values (ALU result, store data) to 16-bit halfwords for the halfword store/immediate-pack path.
- Operates as the inverse of the 16-to-32 extension stage: it checks that the narrowed value still represents the original value, and either truncates or saturates it.
- Streaming block with a valid/ready handshake on both sides and a 2-entry output buffer.
- Keeps a sticky overflow flag and a saturating overflow counter for debug/exception logic.

---
 rtl/data_narrow_unit.sv | 124 ++++++++++++
 tb/tb_data_narrow_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_narrow_unit.sv
// Narrows IN_W-bit values to OUT_W-bit halfwords with a signed/unsigned range check,
// optional saturation, a 2-entry output FIFO and sticky/counted overflow reporting.
module data_narrow_unit #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic             signed_i,
  input  logic             sat_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             ovf_o,
  input  logic             clr_i,
  output logic             ovf_sticky_o,
  output logic [CNT_W-1:0] ovf_cnt_o
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             ovf;
  } entry_t;

  logic             fits;
  logic             ovf_in;
  logic [OUT_W-1:0] narrow;

  // Range check and saturation of the incoming word.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    fits   = 1'b0;
    narrow = data_i[OUT_W-1:0];
    if (signed_i) begin
      fits = (&data_i[IN_W-1:OUT_W-1]) | ~(|data_i[IN_W-1:OUT_W-1]);
    end else begin
      fits = ~(|data_i[IN_W-1:OUT_W]);
    end
    ovf_in = ~fits;
    if (ovf_in && sat_i) begin
      if (!signed_i) begin
        narrow = '1;
      end else if (data_i[IN_W-1]) begin
        narrow = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        narrow = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

  entry_t     mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign data_o      = out_valid_o ? mem_q[rd_ptr_q].data : '0;
  assign ovf_o       = out_valid_o ? mem_q[rd_ptr_q].ovf  : 1'b0;

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; count_q gates every read so stale contents never leak.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: narrow, ovf: ovf_in};
    end
  end

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_base;
  logic             ovf_event;

  assign ovf_event = push && ovf_in;

  // A clear in the same cycle as an event is applied before the event.
  always_comb begin
    cnt_base = clr_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (ovf_event && (cnt_base != '1)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
    sticky_d = (sticky_q && !clr_i) || ovf_event;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ovf_sticky_o = sticky_q;
  assign ovf_cnt_o    = cnt_q;

endmodule

// File: tb/tb_data_narrow_unit.sv
// Directed self-checking bench for data_narrow_unit with hand-computed expectations.
module tb_data_narrow_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] data_i;
  logic        signed_i;
  logic        sat_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] data_o;
  logic        ovf_o;
  logic        clr_i;
  logic        ovf_sticky_o;
  logic [7:0]  ovf_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] got_q[$];
  logic        acc;

  always #5 clk = ~clk;

  data_narrow_unit #(.IN_W(32), .OUT_W(16), .CNT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .signed_i    (signed_i),
    .sat_i       (sat_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .ovf_o       (ovf_o),
    .clr_i       (clr_i),
    .ovf_sticky_o(ovf_sticky_o),
    .ovf_cnt_o   (ovf_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one word for a single edge; caller ensures in_ready_o is high.
  task automatic send(input logic [31:0] d, input logic s, input logic sat);
    in_valid_i = 1'b1;
    data_i     = d;
    signed_i   = s;
    sat_i      = sat;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; data_i = '0; signed_i = 1'b0;
    sat_i = 1'b0; out_ready_i = 1'b1; clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_data", data_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_sticky", ovf_sticky_o, 0);
    check("rst_cnt", ovf_cnt_o, 0);
    rst_i = 1'b1;

    // Streaming with consumer always ready.
    send(32'hFFFF8000, 1'b1, 1'b1);
    check("sfit_valid", out_valid_o, 1);
    check("sfit_data", data_o, 16'h8000);
    check("sfit_ovf", ovf_o, 0);
    check("sfit_cnt", ovf_cnt_o, 0);
    check("sfit_sticky", ovf_sticky_o, 0);

    send(32'h00012345, 1'b1, 1'b1);
    check("ssat_data", data_o, 16'h7FFF);
    check("ssat_ovf", ovf_o, 1);
    check("ssat_sticky", ovf_sticky_o, 1);
    check("ssat_cnt", ovf_cnt_o, 1);

    send(32'hFFFE0000, 1'b1, 1'b0);
    check("strunc_data", data_o, 16'h0000);
    check("strunc_ovf", ovf_o, 1);
    check("strunc_cnt", ovf_cnt_o, 2);

    send(32'h0000FFFF, 1'b0, 1'b1);
    check("ufit_data", data_o, 16'hFFFF);
    check("ufit_ovf", ovf_o, 0);
    check("ufit_cnt", ovf_cnt_o, 2);

    send(32'h00010000, 1'b0, 1'b1);
    check("usat_data", data_o, 16'hFFFF);
    check("usat_ovf", ovf_o, 1);
    check("usat_cnt", ovf_cnt_o, 3);

    send(32'h80000000, 1'b1, 1'b1);
    check("sneg_data", data_o, 16'h8000);
    check("sneg_ovf", ovf_o, 1);

    send(32'h00007FFF, 1'b1, 1'b1);
    check("smax_data", data_o, 16'h7FFF);
    check("smax_ovf", ovf_o, 0);
    check("smax_cnt", ovf_cnt_o, 4);

    @(posedge clk);
    #1;
    check("drain_valid", out_valid_o, 0);
    check("drain_data", data_o, 0);

    // Backpressure: two entries fill the buffer, the third is held off.
    out_ready_i = 1'b0;
    send(32'h1, 1'b0, 1'b0);
    check("bp_ready1", in_ready_o, 1);
    send(32'h2, 1'b0, 1'b0);
    check("bp_ready_full", in_ready_o, 0);
    check("bp_head", data_o, 16'h0001);
    in_valid_i = 1'b1; data_i = 32'h3; signed_i = 1'b0; sat_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_held_ready", in_ready_o, 0);
    check("bp_stable_data", data_o, 16'h0001);
    check("bp_stable_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_o) got_q.push_back(data_o);
      acc = in_valid_i && in_ready_o;
      @(posedge clk);
      #1;
      if (acc) in_valid_i = 1'b0;
    end
    check("bp_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check($sformatf("bp_order%0d", i), got_q[i], i + 1);
    end

    // Counter saturation over 300 overflowing words (4 already counted).
    in_valid_i = 1'b1; data_i = 32'h00010000; signed_i = 1'b0; sat_i = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("cnt_sat", ovf_cnt_o, 255);
    check("cnt_sticky", ovf_sticky_o, 1);

    clr_i = 1'b1;
    @(posedge clk);
    #1;
    check("clr_evt_cnt", ovf_cnt_o, 1);
    check("clr_evt_sticky", ovf_sticky_o, 1);
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    check("clr_cnt", ovf_cnt_o, 0);
    check("clr_sticky", ovf_sticky_o, 0);

    // Fill the buffer, then reset asynchronously mid-cycle.
    out_ready_i = 1'b0;
    send(32'h00007FFF, 1'b1, 1'b1);
    check("fill_head", data_o, 16'h7FFF);
    check("fill_sticky", ovf_sticky_o, 0);
    send(32'h80000000, 1'b1, 1'b1);
    check("fill_full", in_ready_o, 0);
    check("fill_cnt", ovf_cnt_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_ready", in_ready_o, 1);
    check("arst_cnt", ovf_cnt_o, 0);
    check("arst_sticky", ovf_sticky_o, 0);
    check("arst_data", data_o, 0);
    #3 rst_i = 1'b1;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_valid", out_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
